acc_dump_8: RTL and testbench

ACC_DUMP_8 -- requirements
Module: acc_dump_8

---
 rtl/acc_dump_pkg.sv | 14 +
 rtl/acc_add_sat.sv | 36 +++
 rtl/acc_dump_8.sv | 88 ++++++++
 tb/tb_acc_dump_8.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_dump_pkg.sv
// acc_dump_pkg: shared widths and saturation limits for acc_dump_8.
// Saturation is built only when ACC_DUMP_SAT_EN is defined.
package acc_dump_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int OUT_W_DEF = 16;
  localparam int RATE_W    = 8;

  localparam logic [OUT_W_DEF-1:0] SAT_MAX_DEF =
    {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic [OUT_W_DEF-1:0] SAT_MIN_DEF =
    {1'b1, {(OUT_W_DEF-1){1'b0}}};

endpackage

// File: rtl/acc_add_sat.sv
// acc_add_sat: signed W-bit adder with overflow detect.
// ACC_DUMP_SAT_EN defined: clamps to the signed range on overflow.
module acc_add_sat
  import acc_dump_pkg::*;
#(
  parameter int W = OUT_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

`ifdef ACC_DUMP_SAT_EN
  localparam logic [W-1:0] LIM_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] LIM_MIN = {1'b1, {(W-1){1'b0}}};
`endif

  logic [W-1:0] raw;

  // Same-sign operands giving a different-sign result overflowed
  always_comb begin
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef ACC_DUMP_SAT_EN
    if (ovf) begin
      sum = a[W-1] ? LIM_MIN : LIM_MAX;
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/acc_dump_8.sv
// acc_dump_8: accumulate rate+1 signed samples, then dump the sum.
// Optional saturation via ACC_DUMP_SAT_EN (see acc_add_sat).
module acc_dump_8
  import acc_dump_pkg::*;
#(
  parameter int IN_WIDTH  = IN_W_DEF,
  parameter int OUT_WIDTH = OUT_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [RATE_W-1:0]    rate,
  input  logic                 strobe_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic                 strobe_out,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 overflow
);

  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [RATE_W-1:0]    cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 stb_q, stb_d;
  logic                 ovf_q, ovf_d;

  logic signed [IN_WIDTH-1:0] din_s;
  logic [OUT_WIDTH-1:0]       din_ext;
  logic [OUT_WIDTH-1:0]       add_sum;
  logic                       add_ovf;

  assign din_s   = data_in;
  assign din_ext = OUT_WIDTH'(din_s);

  acc_add_sat #(
    .W (OUT_WIDTH)
  ) u_add (
    .a   (acc_q),
    .b   (din_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Frame control: accumulate, dump on the last sample, clear on !enable
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    stb_d  = 1'b0;
    ovf_d  = ovf_q;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (strobe_in) begin
      ovf_d = ovf_q | add_ovf;
      if (cnt_q >= rate) begin
        dout_d = add_sum;
        acc_d  = '0;
        cnt_d  = '0;
        stb_d  = 1'b1;
      end else begin
        acc_d = add_sum;
        cnt_d = cnt_q + RATE_W'(1);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      stb_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      stb_q  <= stb_d;
      ovf_q  <= ovf_d;
    end
  end

  assign strobe_out = stb_q;
  assign data_out   = dout_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_acc_dump_8.sv
// tb_acc_dump_8: directed and random checks of acc_dump_8
// at OUT_WIDTH 16 and 8, against an arithmetic reference model.
module tb_acc_dump_8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  rate;
  logic        strobe_in;
  logic [7:0]  data_in;
  logic        strobe_out, strobe_out8;
  logic [15:0] data_out;
  logic [7:0]  data_out8;
  logic        overflow, overflow8;

  int n_tests = 0;
  int n_fail  = 0;

  longint m_acc [2];
  longint m_out [2];
  bit     m_ovf [2];
  int     m_cnt;
  bit     m_stb;
  int     wid [2] = '{16, 8};

  acc_dump_8 #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .data_in    (data_in),
    .strobe_out (strobe_out),
    .data_out   (data_out),
    .overflow   (overflow)
  );

  acc_dump_8 #(.IN_WIDTH(8), .OUT_WIDTH(8)) dut8 (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .data_in    (data_in),
    .strobe_out (strobe_out8),
    .data_out   (data_out8),
    .overflow   (overflow8)
  );

  always #5 clock = ~clock;

  function automatic longint add_w(input int w, input longint a,
                                   input longint b, output bit ov);
    longint s, mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    s  = a + b;
    ov = (s > mx) || (s < mn);
`ifdef ACC_DUMP_SAT_EN
    if (s > mx) s = mx;
    else if (s < mn) s = mn;
`else
    if (s > mx) s = s - (longint'(1) <<< w);
    else if (s < mn) s = s + (longint'(1) <<< w);
`endif
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_out[k] = 0;
      m_ovf[k] = 0;
    end
    m_cnt = 0;
    m_stb = 0;
  endtask

  task automatic step(input bit en, input bit stb,
                      input logic [7:0] d, input logic [7:0] r);
    bit     ov, dump;
    longint s;
    enable    = en;
    strobe_in = stb;
    data_in   = d;
    rate      = r;
    @(posedge clock);
    m_stb = 0;
    if (!en) begin
      m_acc[0] = 0;
      m_acc[1] = 0;
      m_cnt    = 0;
    end else if (stb) begin
      dump = (m_cnt >= int'(r));
      for (int k = 0; k < 2; k++) begin
        s = add_w(wid[k], m_acc[k], longint'($signed(d)), ov);
        m_ovf[k] = m_ovf[k] | ov;
        if (dump) begin
          m_out[k] = s;
          m_acc[k] = 0;
        end else begin
          m_acc[k] = s;
        end
      end
      if (dump) begin
        m_cnt = 0;
        m_stb = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    strobe_in = 1'b0;
    data_in   = '0;
    rate      = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (strobe_out !== 1'b0 || data_out !== 16'h0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset16 got stb=%b dout=%h ovf=%b exp 0/0000/0",
               strobe_out, data_out, overflow);
    end
    n_tests++;
    if (strobe_out8 !== 1'b0 || data_out8 !== 8'h0 || overflow8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8 got stb=%b dout=%h ovf=%b exp 0/00/0",
               strobe_out8, data_out8, overflow8);
    end
    #3 reset_n = 1'b1;
    step(1, 0, 8'h0, 8'd3);
  endtask

  task automatic test_frame();
    logic e;
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 8'(i), 8'd3);
      e = (i == 4);
      n_tests++;
      if (strobe_out !== e) begin
        n_fail++;
        $display("FAIL frame_stb%0d got %b exp %b", i, strobe_out, e);
      end
    end
    n_tests++;
    if (data_out !== 16'd10 || data_out8 !== 8'd10) begin
      n_fail++;
      $display("FAIL frame_sum got %0d/%0d exp 10/10", data_out, data_out8);
    end
    step(1, 0, 8'h55, 8'd3);
    n_tests++;
    if (strobe_out !== 1'b0 || data_out !== 16'd10) begin
      n_fail++;
      $display("FAIL frame_hold got stb=%b dout=%0d exp 0/10",
               strobe_out, data_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 8'hFB, 8'd0);
      n_tests++;
      if (strobe_out !== 1'b1 || data_out !== 16'hFFFB ||
          strobe_out8 !== 1'b1 || data_out8 !== 8'hFB) begin
        n_fail++;
        $display("FAIL b2b_%0d got %b/%h %b/%h exp 1/fffb 1/fb",
                 i, strobe_out, data_out, strobe_out8, data_out8);
      end
    end
    step(1, 0, 8'h0, 8'd0);
    n_tests++;
    if (strobe_out !== 1'b0 || data_out !== 16'hFFFB) begin
      n_fail++;
      $display("FAIL b2b_idle got %b/%h exp 0/fffb", strobe_out, data_out);
    end
  endtask

  task automatic test_long_frame();
    int         early;
    logic [7:0] e8;
    early = 0;
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 8'd127, 8'd255);
      if (i < 255 && strobe_out === 1'b1) early++;
    end
    n_tests++;
    if (early != 0 || strobe_out !== 1'b1) begin
      n_fail++;
      $display("FAIL long_stb got early=%0d last=%b exp 0/1",
               early, strobe_out);
    end
    n_tests++;
    if (data_out !== 16'd32512 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL long16 got %0d ovf=%b exp 32512 ovf=0",
               data_out, overflow);
    end
`ifdef ACC_DUMP_SAT_EN
    e8 = 8'h7F;
`else
    e8 = 8'h00;
`endif
    n_tests++;
    if (data_out8 !== e8 || overflow8 !== 1'b1) begin
      n_fail++;
      $display("FAIL long8 got %h ovf=%b exp %h ovf=1",
               data_out8, overflow8, e8);
    end
  endtask

  task automatic test_rate_change();
    for (int i = 0; i < 3; i++) step(1, 1, 8'd10, 8'd7);
    n_tests++;
    if (strobe_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rchg_pre got stb=%b exp 0", strobe_out);
    end
    step(1, 1, 8'd10, 8'd2);
    n_tests++;
    if (strobe_out !== 1'b1 || data_out !== 16'd40 || data_out8 !== 8'd40) begin
      n_fail++;
      $display("FAIL rchg_dump got %b/%0d/%0d exp 1/40/40",
               strobe_out, data_out, data_out8);
    end
  endtask

  task automatic test_enable();
    int seen;
    seen = 0;
    step(1, 1, 8'd1, 8'd3);
    step(1, 1, 8'd1, 8'd3);
    step(0, 1, 8'd1, 8'd3);
    n_tests++;
    if (strobe_out !== 1'b0 || data_out !== 16'd40 || data_out8 !== 8'd40) begin
      n_fail++;
      $display("FAIL en_hold got %b/%0d/%0d exp 0/40/40",
               strobe_out, data_out, data_out8);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 8'd1, 8'd3);
      if (strobe_out === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 1 || strobe_out !== 1'b1 || data_out !== 16'd4) begin
      n_fail++;
      $display("FAIL en_frame got dumps=%0d last=%b dout=%0d exp 1/1/4",
               seen, strobe_out, data_out);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    step(1, 1, 8'd5, 8'd3);
    step(1, 1, 8'd5, 8'd3);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (strobe_out !== 1'b0 || data_out !== 16'h0 || overflow !== 1'b0 ||
        data_out8 !== 8'h0 || overflow8 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got %b/%h/%b %h/%b exp all 0",
               strobe_out, data_out, overflow, data_out8, overflow8);
    end
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 8'd2, 8'd3);
      if (strobe_out === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 1 || strobe_out !== 1'b1 || data_out !== 16'd8) begin
      n_fail++;
      $display("FAIL rst_frame got dumps=%0d last=%b dout=%0d exp 1/1/8",
               seen, strobe_out, data_out);
    end
  endtask

  task automatic test_random();
    bit         en, stb;
    logic [7:0] d, r;
    int         bad;
    bad = 0;
    r = 8'd2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        r = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                        : 8'($urandom_range(0, 4));
      end
      en  = ($urandom_range(0, 19) != 0);
      stb = ($urandom_range(0, 2) != 0);
      d   = 8'($urandom);
      step(en, stb, d, r);
      n_tests++;
      if (strobe_out !== m_stb || strobe_out8 !== m_stb ||
          data_out !== m_out[0][15:0] || data_out8 !== m_out[1][7:0] ||
          overflow !== m_ovf[0] || overflow8 !== m_ovf[1]) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL rand_%0d got %b/%h/%b %b/%h/%b exp %b/%h/%b %b/%h/%b",
                   i, strobe_out, data_out, overflow,
                   strobe_out8, data_out8, overflow8,
                   m_stb, m_out[0][15:0], m_ovf[0],
                   m_stb, m_out[1][7:0], m_ovf[1]);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_long_frame();
    test_rate_change();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
